// File: rtl/page_reg_pkg.sv
// Shared types and helpers for the page register bank sequencer and its bank benches.
package page_reg_pkg;

  localparam int PR_LANES   = 4;
  localparam int PR_ENTRIES = 8;
  localparam int PR_SEL_W   = $clog2(PR_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_CLEAR
  } pr_state_e;

  function automatic logic [PR_ENTRIES-1:0] onehot_dec(input logic [PR_SEL_W-1:0] idx);
    logic [PR_ENTRIES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the side that did not win last time wins a tie.
// Latency: combinational grant, last-winner flop updates on the accepting edge.
// Backpressure: losing requester simply stays pending; nothing changes unless adv is high.
module rr_arb2
  import page_reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic adv,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b_q;
  logic last_b_d;

  always_comb begin
    gnt_a    = req_a & (~req_b | last_b_q);
    gnt_b    = req_b & ~gnt_a;
    last_b_d = last_b_q;
    if (adv && (req_a || req_b)) begin
      last_b_d = gnt_b;
    end
  end

  // Starts as "B won last" so the first tie after reset goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/page_reg_ctrl.sv
// Sequencer/arbiter for the byte-lane page register banks, plus a self-timed clear.
// Latency: grant + bank load 1 cycle after REQ; read data 2 cycles after REQ; clear takes ENTRIES cycles.
// Backpressure: REQ is held until GNT; clear and TEST_MODE stall all grants.
module page_reg_ctrl
  import page_reg_pkg::*;
#(
  parameter int LANES   = PR_LANES,
  parameter int ENTRIES = PR_ENTRIES,
  parameter int SEL_W   = $clog2(ENTRIES)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 REQ_A,
  input  logic                 REQ_B,
  input  logic                 WR_A,
  input  logic                 WR_B,
  input  logic [SEL_W-1:0]     IDX_A,
  input  logic [SEL_W-1:0]     IDX_B,
  input  logic [LANES-1:0]     BE_A,
  input  logic [LANES-1:0]     BE_B,
  input  logic [8*LANES-1:0]   WD_A,
  input  logic [8*LANES-1:0]   WD_B,
  output logic                 GNT_A,
  output logic                 GNT_B,
  output logic                 RVALID_A,
  output logic                 RVALID_B,
  output logic [8*LANES-1:0]   RDATA,
  input  logic                 CLR_REQ,
  output logic                 CLR_BUSY,
  input  logic                 TEST_MODE,
  output logic [8*LANES-1:0]   DATA_RES,
  output logic [LANES-1:0]     EN_B,
  output logic [ENTRIES-1:0]   EN_ENT,
  output logic [SEL_W-1:0]     PAGE_SEL,
  input  logic [8*LANES-1:0]   PAGE
);

  pr_state_e            state_q, state_d;
  logic                 gnt_a_q, gnt_a_d;
  logic                 gnt_b_q, gnt_b_d;
  logic                 rvalid_a_q, rvalid_a_d;
  logic                 rvalid_b_q, rvalid_b_d;
  logic [8*LANES-1:0]   rdata_q, rdata_d;
  logic                 clr_busy_q, clr_busy_d;
  logic [8*LANES-1:0]   data_res_q, data_res_d;
  logic [LANES-1:0]     en_b_q, en_b_d;
  logic [ENTRIES-1:0]   en_ent_q, en_ent_d;
  logic [SEL_W-1:0]     page_sel_q, page_sel_d;
  logic [SEL_W-1:0]     cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic                 win_b_q, win_b_d;

  logic                 arb_go;
  logic                 arb_gnt_a;
  logic                 arb_gnt_b;
  logic                 sel_wr;
  logic [SEL_W-1:0]     sel_idx;
  logic [LANES-1:0]     sel_be;
  logic [8*LANES-1:0]   sel_wd;

  // Arbitration only counts when the idle FSM is really free to start an access.
  assign arb_go = (state_q == ST_IDLE) && !TEST_MODE && !CLR_REQ;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RESET_N),
    .req_a (REQ_A),
    .req_b (REQ_B),
    .adv   (arb_go),
    .gnt_a (arb_gnt_a),
    .gnt_b (arb_gnt_b)
  );

  assign sel_wr  = arb_gnt_b ? WR_B  : WR_A;
  assign sel_idx = arb_gnt_b ? IDX_B : IDX_A;
  assign sel_be  = arb_gnt_b ? BE_B  : BE_A;
  assign sel_wd  = arb_gnt_b ? WD_B  : WD_A;

  always_comb begin
    state_d    = state_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    rdata_d    = rdata_q;
    clr_busy_d = 1'b0;
    data_res_d = '0;
    en_b_d     = '0;
    en_ent_d   = '0;
    page_sel_d = page_sel_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    win_b_d    = win_b_q;

    case (state_q)
      ST_IDLE: begin
        if (!TEST_MODE) begin
          if (CLR_REQ) begin
            state_d    = ST_CLEAR;
            clr_busy_d = 1'b1;
            en_b_d     = '1;
            en_ent_d   = onehot_dec(cnt_q);
          end else if (arb_gnt_a || arb_gnt_b) begin
            state_d = ST_ACCESS;
            gnt_a_d = arb_gnt_a;
            gnt_b_d = arb_gnt_b;
            win_b_d = arb_gnt_b;
            wr_d    = sel_wr;
            if (sel_wr) begin
              en_b_d     = sel_be;
              en_ent_d   = onehot_dec(sel_idx);
              data_res_d = sel_wd;
            end else begin
              page_sel_d = sel_idx;
            end
          end
        end
      end

      ST_ACCESS: begin
        if (!wr_q && !TEST_MODE) begin
          state_d    = ST_RESP;
          rdata_d    = PAGE;
          rvalid_a_d = !win_b_q;
          rvalid_b_d = win_b_q;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      ST_CLEAR: begin
        // Test mode abandons the sweep; the counter rewinds so a fresh request starts at entry 0.
        if (TEST_MODE || (cnt_q == SEL_W'(ENTRIES - 1))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + SEL_W'(1);
          clr_busy_d = 1'b1;
          en_b_d     = '1;
          en_ent_d   = onehot_dec(cnt_q + SEL_W'(1));
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_q    <= '0;
      clr_busy_q <= 1'b0;
      data_res_q <= '0;
      en_b_q     <= '0;
      en_ent_q   <= '0;
      page_sel_q <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      win_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_q    <= rdata_d;
      clr_busy_q <= clr_busy_d;
      data_res_q <= data_res_d;
      en_b_q     <= en_b_d;
      en_ent_q   <= en_ent_d;
      page_sel_q <= page_sel_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      win_b_q    <= win_b_d;
    end
  end

  assign GNT_A    = gnt_a_q;
  assign GNT_B    = gnt_b_q;
  assign RVALID_A = rvalid_a_q;
  assign RVALID_B = rvalid_b_q;
  assign RDATA    = rdata_q;
  assign CLR_BUSY = clr_busy_q;
  assign DATA_RES = data_res_q;
  assign PAGE_SEL = page_sel_q;
  // Scan must never see a bank load, even in the cycle TEST_MODE rises.
  assign EN_B     = en_b_q & {LANES{~TEST_MODE}};
  assign EN_ENT   = en_ent_q & {ENTRIES{~TEST_MODE}};

endmodule

// File: tb/tb_page_reg_ctrl.sv
// Bench for page_reg_ctrl: behavioural bank, reference page memory and round-robin model.
module tb_page_reg_ctrl;

  localparam int LANES   = 4;
  localparam int ENTRIES = 8;
  localparam int SEL_W   = 3;
  localparam int DW      = 8 * LANES;

  typedef struct {
    bit          wr;
    logic [2:0]  idx;
    logic [3:0]  be;
    logic [31:0] wd;
  } tx_t;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic               REQ_A, REQ_B, WR_A, WR_B;
  logic [SEL_W-1:0]   IDX_A, IDX_B;
  logic [LANES-1:0]   BE_A, BE_B;
  logic [DW-1:0]      WD_A, WD_B;
  logic               GNT_A, GNT_B, RVALID_A, RVALID_B;
  logic [DW-1:0]      RDATA;
  logic               CLR_REQ, CLR_BUSY, TEST_MODE;
  logic [DW-1:0]      DATA_RES;
  logic [LANES-1:0]   EN_B;
  logic [ENTRIES-1:0] EN_ENT;
  logic [SEL_W-1:0]   PAGE_SEL;
  logic [DW-1:0]      PAGE;

  page_reg_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .WR_A(WR_A), .WR_B(WR_B),
    .IDX_A(IDX_A), .IDX_B(IDX_B), .BE_A(BE_A), .BE_B(BE_B),
    .WD_A(WD_A), .WD_B(WD_B), .GNT_A(GNT_A), .GNT_B(GNT_B),
    .RVALID_A(RVALID_A), .RVALID_B(RVALID_B), .RDATA(RDATA),
    .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY), .TEST_MODE(TEST_MODE),
    .DATA_RES(DATA_RES), .EN_B(EN_B), .EN_ENT(EN_ENT),
    .PAGE_SEL(PAGE_SEL), .PAGE(PAGE)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the four MUX_REG_8x8 lanes.
  logic [DW-1:0] bank [ENTRIES];
  always @(posedge CLK)
    for (int e = 0; e < ENTRIES; e++)
      if (EN_ENT[e])
        for (int l = 0; l < LANES; l++)
          if (EN_B[l]) bank[e][8*l +: 8] <= DATA_RES[8*l +: 8];
  assign PAGE = bank[PAGE_SEL];

  logic [31:0] ref_mem [ENTRIES];
  bit          last_b_m = 1'b1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  function automatic tx_t mk(input bit wr, input int idx, input logic [3:0] be, input logic [31:0] wd);
    tx_t t;
    t.wr = wr; t.idx = 3'(idx); t.be = be; t.wd = wd;
    return t;
  endfunction

  function automatic tx_t rnd_tx();
    return mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom_range(0, 15)), $urandom);
  endfunction

  // Issue one or two requests from IDLE and follow them to completion.
  task automatic run(input bit ua, input bit ub, input tx_t ta, input tx_t tbx);
    bit  pa, pb, wb, first;
    tx_t t;
    int  n;
    pa = ua; pb = ub; first = 1'b1; n = 0;
    REQ_A = ua; WR_A = ta.wr;  IDX_A = ta.idx;  BE_A = ta.be;  WD_A = ta.wd;
    REQ_B = ub; WR_B = tbx.wr; IDX_B = tbx.idx; BE_B = tbx.be; WD_B = tbx.wd;
    while ((pa || pb) && n < 12) begin
      tick(); n++;
      if (GNT_A === 1'b1 || GNT_B === 1'b1) begin
        wb = (pa && pb) ? !last_b_m : pb;
        if (first) chk("gnt_latency", n, 1);
        first = 1'b0;
        chk("gnt_a", GNT_A, !wb);
        chk("gnt_b", GNT_B, wb);
        last_b_m = wb;
        t = wb ? tbx : ta;
        if (wb) begin pb = 1'b0; REQ_B = 1'b0; end
        else    begin pa = 1'b0; REQ_A = 1'b0; end
        if (t.wr) begin
          chk("wr_en_ent", EN_ENT, 32'(1) << t.idx);
          chk("wr_en_b", EN_B, t.be);
          chk("wr_data", DATA_RES, t.wd);
          ref_mem[t.idx] = merge(ref_mem[t.idx], t.wd, t.be);
          tick();
          chk("wr_en_b_off", EN_B, 0);
          chk("wr_en_ent_off", EN_ENT, 0);
        end else begin
          chk("rd_page_sel", PAGE_SEL, t.idx);
          chk("rd_en_b", EN_B, 0);
          tick();
          chk("rvalid_a", RVALID_A, !wb);
          chk("rvalid_b", RVALID_B, wb);
          chk("rdata", RDATA, ref_mem[t.idx]);
          tick();
        end
        n = 0;
      end
    end
    chk("run_timeout", {30'd0, pa, pb}, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"}, {GNT_A, GNT_B}, 0);
    chk({tag, "_rvalid"}, {RVALID_A, RVALID_B}, 0);
    chk({tag, "_rdata"}, RDATA, 0);
    chk({tag, "_clr_busy"}, CLR_BUSY, 0);
    chk({tag, "_data_res"}, DATA_RES, 0);
    chk({tag, "_en_b"}, EN_B, 0);
    chk({tag, "_en_ent"}, EN_ENT, 0);
    chk({tag, "_page_sel"}, PAGE_SEL, 0);
  endtask

  initial begin
    int  ng, n, mode;
    bit  wb;
    tx_t idle_tx;
    idle_tx = mk(0, 0, 0, 0);
    RESET_N = 1'b0; REQ_A = 0; REQ_B = 0; WR_A = 0; WR_B = 0;
    IDX_A = 0; IDX_B = 0; BE_A = 0; BE_B = 0; WD_A = 0; WD_B = 0;
    CLR_REQ = 0; TEST_MODE = 0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    RESET_N = 1'b1;
    tick();

    // Full write then read-back by A.
    run(1, 0, mk(1, 3, 4'hF, 32'hDEADBEEF), idle_tx);
    run(1, 0, mk(0, 3, 4'h0, 32'h0), idle_tx);
    chk("rd_deadbeef", RDATA, 32'hDEADBEEF);

    // B takes a turn so the tie below starts with A.
    run(0, 1, idle_tx, mk(1, 5, 4'hF, 32'hFFFFFFFF));

    // Both held high through four grants.
    REQ_A = 1; WR_A = 1; IDX_A = 0; BE_A = 4'hF; WD_A = 32'hA0A0A0A0;
    REQ_B = 1; WR_B = 1; IDX_B = 1; BE_B = 4'hF; WD_B = 32'hB1B1B1B1;
    ng = 0; n = 0;
    while (ng < 4 && n < 20) begin
      tick(); n++;
      if (GNT_A === 1'b1 || GNT_B === 1'b1) begin
        wb = !last_b_m;
        chk("tie_gnt_a", GNT_A, !wb);
        chk("tie_order", GNT_B, ng % 2);
        last_b_m = wb;
        ref_mem[wb ? 1 : 0] = wb ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
        ng++;
        if (ng == 4) begin REQ_A = 0; REQ_B = 0; end
      end
    end
    chk("tie_count", ng, 4);
    chk("tie_rate", n, 7);
    tick();

    // Partial write over all-ones.
    run(1, 0, mk(1, 5, 4'b0101, 32'h11223344), idle_tx);
    run(1, 0, mk(0, 5, 4'h0, 32'h0), idle_tx);
    chk("partial_rd", RDATA, 32'hFF22FF44);

    // Clear with B pending; a second CLR_REQ mid-sweep is ignored.
    CLR_REQ = 1; REQ_B = 1; WR_B = 0; IDX_B = 3;
    for (int i = 0; i < ENTRIES; i++) begin
      tick();
      chk("clr_busy", CLR_BUSY, 1);
      chk("clr_en_ent", EN_ENT, 32'(1) << i);
      chk("clr_en_b", EN_B, 4'hF);
      chk("clr_data", DATA_RES, 0);
      chk("clr_no_gnt_b", GNT_B, 0);
      CLR_REQ = (i == 3);
    end
    for (int e = 0; e < ENTRIES; e++) ref_mem[e] = 32'h0;
    tick();
    chk("clr_done_busy", CLR_BUSY, 0);
    chk("clr_done_no_gnt", GNT_B, 0);
    run(0, 1, idle_tx, mk(0, 3, 4'h0, 32'h0));
    for (int e = 0; e < ENTRIES; e++) run(1, 0, mk(0, e, 4'h0, 32'h0), idle_tx);

    // Refill, then abort a clear with TEST_MODE at step 3.
    for (int e = 0; e < ENTRIES; e++) run(1, 0, mk(1, e, 4'hF, $urandom), idle_tx);
    CLR_REQ = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      CLR_REQ = 0;
      chk("tm_clr_step", EN_ENT, 32'(1) << i);
    end
    TEST_MODE = 1;
    REQ_A = 1; WR_A = 0; IDX_A = 3;
    #1;
    chk("tm_en_b_forced", EN_B, 0);
    chk("tm_en_ent_forced", EN_ENT, 0);
    for (int e = 0; e < 3; e++) ref_mem[e] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tm_busy_low", CLR_BUSY, 0);
      chk("tm_no_gnt", {GNT_A, GNT_B}, 0);
    end
    TEST_MODE = 0;
    for (int e = 0; e < ENTRIES; e++) run(1, 0, mk(0, (e + 3) % ENTRIES, 4'h0, 32'h0), idle_tx);

    // Asynchronous reset in the middle of a read.
    REQ_A = 1; WR_A = 0; IDX_A = 6;
    tick();
    chk("rst_rd_gnt", GNT_A, 1);
    chk("rst_rd_sel", PAGE_SEL, 6);
    REQ_A = 0;
    #2 RESET_N = 1'b0;
    #1 chk_zero_outputs("async_rst");
    tick();
    chk("rst_no_rvalid", RVALID_A, 0);
    RESET_N = 1'b1;
    last_b_m = 1'b1;
    tick();
    run(1, 1, rnd_tx(), rnd_tx());

    // Random traffic against the reference model.
    repeat (40) begin
      mode = $urandom_range(0, 2);
      run(mode != 1, mode != 0, rnd_tx(), rnd_tx());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
